// File: rtl/fir_bist_if.sv
// fir_bist_if: stimulus/response handshake between the FIR BIST harness and
// the filter under test. The harness holds the master modport and the
// filter holds the slave modport.
interface fir_bist_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 32
) ();
    logic [DATA_W-1:0] stim_data;
    logic              stim_valid;
    logic              stim_ready;
    logic [OUT_W-1:0]  resp_data;
    logic              resp_valid;

    modport master (
        output stim_data,
        output stim_valid,
        input  stim_ready,
        input  resp_data,
        input  resp_valid
    );

    modport slave (
        input  stim_data,
        input  stim_valid,
        output stim_ready,
        output resp_data,
        output resp_valid
    );
endinterface

// File: rtl/fir_bist_harness.sv
// fir_bist_harness: drives a programmable stimulus stream (impulse, step,
// ramp or LFSR) into a FIR_N filter, folds the responses into a MISR
// signature and reports pass/fail against a runtime expected signature.
// Optional feature: define FIR_BIST_TIMEOUT_EN to build the idle-response
// watchdog; without it, timeout stays 0 and a silent DUT parks the harness
// in DRAIN until rst.
module fir_bist_harness #(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       OUT_W       = 32,
    parameter int unsigned       SIG_W       = 32,
    parameter int unsigned       NUM_SAMPLES = 256,
    parameter logic [DATA_W-1:0] LFSR_POLY   = 16'hB400,
    parameter logic [DATA_W-1:0] LFSR_SEED   = 16'h0001,
    parameter logic [SIG_W-1:0]  MISR_POLY   = 32'h04C11DB7,
    parameter int unsigned       TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [SIG_W-1:0]  exp_sig,
    fir_bist_if.master        bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [SIG_W-1:0]  signature,
    output logic [15:0]       err_count
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_CHECK = 2'd3;

    localparam logic [1:0] MODE_IMPULSE = 2'd0;
    localparam logic [1:0] MODE_STEP    = 2'd1;
    localparam logic [1:0] MODE_RAMP    = 2'd2;
    localparam logic [1:0] MODE_LFSR    = 2'd3;

    // Beat counter is at least DATA_W wide so the ramp is a plain slice.
    localparam int unsigned      CNT_W      = (DATA_W > 16) ? DATA_W : 16;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [15:0]      RESP_TOTAL = 16'(NUM_SAMPLES);
    localparam logic [DATA_W-1:0] HALF_SCALE = DATA_W'(1) << (DATA_W - 2);

    // Reject illegal configurations at elaboration.
    if (SIG_W < 8 || NUM_SAMPLES < 1 || NUM_SAMPLES > 65535 || TIMEOUT < 1 ||
        LFSR_SEED == {DATA_W{1'b0}}) begin : g_param_check
        $error("fir_bist_harness: parameter out of range");
    end

    // Stimulus value for beat idx in mode m, given the LFSR state for that beat.
    function automatic logic [DATA_W-1:0] beat_value(input logic [1:0]        m,
                                                     input logic [CNT_W-1:0]  idx,
                                                     input logic [DATA_W-1:0] lfsr);
        logic [DATA_W-1:0] v;
        case (m)
            MODE_IMPULSE: v = (idx == {CNT_W{1'b0}}) ? HALF_SCALE : {DATA_W{1'b0}};
            MODE_STEP:    v = HALF_SCALE;
            MODE_RAMP:    v = idx[DATA_W-1:0];
            MODE_LFSR:    v = lfsr;
            default:      v = {DATA_W{1'b0}};
        endcase
        return v;
    endfunction

    // Galois LFSR step.
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : {DATA_W{1'b0}});
    endfunction

    // MISR step: shift, feed back the MSB through the polynomial, fold in r.
    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                   input logic [SIG_W-1:0] r);
        return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_POLY : {SIG_W{1'b0}}) ^ r;
    endfunction

    // Saturating 16-bit increment.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'h0001;
    endfunction

    logic [1:0]        state_q,      state_d;
    logic [1:0]        mode_q,       mode_d;
    logic [CNT_W-1:0]  stim_cnt_q,   stim_cnt_d;
    logic [15:0]       resp_cnt_q,   resp_cnt_d;
    logic [DATA_W-1:0] lfsr_q,       lfsr_d;
    logic [SIG_W-1:0]  sig_q,        sig_d;
    logic [DATA_W-1:0] stim_data_q,  stim_data_d;
    logic              stim_valid_q, stim_valid_d;
    logic [15:0]       err_cnt_q,    err_cnt_d;
    logic              pass_q,       pass_d;
    logic              timeout_q,    timeout_d;
    logic              done_q,       done_d;
    logic              busy_q,       busy_d;

    logic              accept_s;
    logic              wd_expire_s;
    logic [DATA_W-1:0] lfsr_adv_s;
    logic [SIG_W-1:0]  resp_fold_s;

    assign accept_s    = stim_valid_q && bus.stim_ready;
    assign lfsr_adv_s  = lfsr_next(lfsr_q);
    // Zero-extends narrow responses, keeps the low SIG_W bits of wide ones.
    assign resp_fold_s = SIG_W'(bus.resp_data);

`ifdef FIR_BIST_TIMEOUT_EN
    localparam int unsigned     WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    logic [WD_W-1:0] wdog_q, wdog_d;

    // Watchdog next value: cleared on run entry and on every response, counts while active.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == ST_IDLE && start) begin
            wdog_d = {WD_W{1'b0}};
        end else if (state_q == ST_DRIVE || state_q == ST_DRAIN) begin
            if (bus.resp_valid) begin
                wdog_d = {WD_W{1'b0}};
            end else if (wdog_q != WD_LIMIT) begin
                wdog_d = wdog_q + WD_W'(1);
            end else begin
                wdog_d = wdog_q;
            end
        end else begin
            wdog_d = wdog_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= {WD_W{1'b0}};
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign wd_expire_s = (state_q == ST_DRIVE || state_q == ST_DRAIN) && (wdog_q == WD_LIMIT);
`else
    assign wd_expire_s = 1'b0;
`endif

    // Run sequencing: stimulus generation, response compaction and result evaluation.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        stim_cnt_d   = stim_cnt_q;
        resp_cnt_d   = resp_cnt_q;
        lfsr_d       = lfsr_q;
        sig_d        = sig_q;
        stim_data_d  = stim_data_q;
        stim_valid_d = stim_valid_q;
        err_cnt_d    = err_cnt_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.resp_valid) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                end else begin
                    err_cnt_d = err_cnt_q;
                end
                if (start) begin
                    state_d      = ST_DRIVE;
                    mode_d       = mode;
                    stim_cnt_d   = {CNT_W{1'b0}};
                    resp_cnt_d   = 16'h0000;
                    err_cnt_d    = 16'h0000;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                    sig_d        = {SIG_W{1'b1}};
                    lfsr_d       = LFSR_SEED;
                    stim_data_d  = beat_value(mode, {CNT_W{1'b0}}, LFSR_SEED);
                    stim_valid_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE, ST_DRAIN: begin
                // Responses are compacted in both states to cover any DUT latency;
                // beats beyond NUM_SAMPLES are flagged as extras.
                if (bus.resp_valid) begin
                    sig_d = misr_next(sig_q, resp_fold_s);
                    if (resp_cnt_q == RESP_TOTAL) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end else begin
                        resp_cnt_d = resp_cnt_q + 16'h0001;
                    end
                end else begin
                    sig_d = sig_q;
                end

                if (wd_expire_s) begin
                    state_d      = ST_CHECK;
                    timeout_d    = 1'b1;
                    stim_valid_d = 1'b0;
                    stim_data_d  = {DATA_W{1'b0}};
                end else if (state_q == ST_DRIVE) begin
                    if (accept_s) begin
                        if (stim_cnt_q == LAST_BEAT) begin
                            state_d      = ST_DRAIN;
                            stim_valid_d = 1'b0;
                            stim_data_d  = {DATA_W{1'b0}};
                        end else begin
                            stim_cnt_d  = stim_cnt_q + CNT_W'(1);
                            lfsr_d      = lfsr_adv_s;
                            stim_data_d = beat_value(mode_q, stim_cnt_q + CNT_W'(1), lfsr_adv_s);
                        end
                    end else begin
                        stim_data_d = stim_data_q;
                    end
                end else begin
                    if (resp_cnt_d == RESP_TOTAL) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_CHECK: begin
                if (bus.resp_valid) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                end else begin
                    err_cnt_d = err_cnt_q;
                end
                pass_d  = (sig_q == exp_sig) && !timeout_q && (err_cnt_q == 16'h0000);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                stim_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= 2'd0;
            stim_cnt_q   <= {CNT_W{1'b0}};
            resp_cnt_q   <= 16'h0000;
            lfsr_q       <= {DATA_W{1'b0}};
            sig_q        <= {SIG_W{1'b0}};
            stim_data_q  <= {DATA_W{1'b0}};
            stim_valid_q <= 1'b0;
            err_cnt_q    <= 16'h0000;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            stim_cnt_q   <= stim_cnt_d;
            resp_cnt_q   <= resp_cnt_d;
            lfsr_q       <= lfsr_d;
            sig_q        <= sig_d;
            stim_data_q  <= stim_data_d;
            stim_valid_q <= stim_valid_d;
            err_cnt_q    <= err_cnt_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.stim_data  = stim_data_q;
    assign bus.stim_valid = stim_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign signature      = sig_q;
    assign err_count      = err_cnt_q;
endmodule

// File: tb/tb_fir_bist_harness.sv
// tb_fir_bist_harness: table-driven runs of the BIST harness against a
// registered loopback DUT, with a stimulus scoreboard and a MISR model.
module tb_fir_bist_harness;
    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] exp_sig = 32'h0;
    logic        busy, done, pass, timeout;
    logic [31:0] signature;
    logic [15:0] err_count;

    logic        rdy = 1'b0;
    logic        lb_en = 1'b0;
    logic        inj_valid = 1'b0;
    logic        lb_valid;
    logic [31:0] lb_data;

    int total = 0;
    int bad = 0;
    int beats_acc = 0;
    logic [15:0] sb_q[$];

    fir_bist_if #(.DATA_W(16), .OUT_W(32)) bus ();

    fir_bist_harness #(
        .DATA_W(16), .OUT_W(32), .SIG_W(32), .NUM_SAMPLES(NS),
        .LFSR_POLY(16'hB400), .LFSR_SEED(16'h0001),
        .MISR_POLY(32'h04C11DB7), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .exp_sig(exp_sig),
        .bus(bus), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .signature(signature), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Loopback DUT: response = accepted stimulus, one cycle later.
    assign bus.stim_ready = rdy;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lb_valid <= 1'b0;
            lb_data  <= 32'h0;
        end else begin
            lb_valid <= lb_en && bus.stim_valid && rdy;
            lb_data  <= {16'h0, bus.stim_data};
        end
    end
    assign bus.resp_valid = lb_valid | inj_valid;
    assign bus.resp_data  = lb_valid ? lb_data : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] r);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ r;
    endfunction

    // Scoreboard: every presented beat must match the queue head; pop on acceptance.
    always @(negedge clk) begin
        if (!rst && bus.stim_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_beat", 32'(sb_q.size()), 32'd1);
            end else begin
                chk("stim_data", 32'(bus.stim_data), 32'(sb_q[0]));
                if (rdy) begin
                    void'(sb_q.pop_front());
                    beats_acc++;
                end
            end
        end
    end

    typedef struct packed {
        logic [1:0]       mode;
        logic             toggle;
        logic [31:0]      flip;
        logic             exp_pass;
        logic [3:0][15:0] beats;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] m, input logic tg, input logic [31:0] fl,
                                input logic ep, input logic [15:0] b0, input logic [15:0] b1,
                                input logic [15:0] b2, input logic [15:0] b3);
        vec_t v;
        v.mode = m; v.toggle = tg; v.flip = fl; v.exp_pass = ep;
        v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3;
        return v;
    endfunction

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input logic loop_on, input int exp_lat,
                           input logic exp_to, input string tag);
        logic [31:0] model;
        int cyc;
        logic seen;
        model = 32'hFFFF_FFFF;
        for (int i = 0; i < NS; i++) begin
            sb_q.push_back(v.beats[i]);
            if (loop_on) model = misr_step(model, {16'h0, v.beats[i]});
        end
        beats_acc = 0;
        lb_en   = loop_on;
        rdy     = 1'b1;
        exp_sig = model ^ v.flip;
        mode    = v.mode;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = ~v.mode;
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        chk({tag, "_valid_rise"}, 32'(bus.stim_valid), 32'd1);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (v.toggle) rdy = ~rdy;
                start = (cyc == 2);
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (exp_lat > 0) chk({tag, "_done_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_pass"}, 32'(pass), 32'(v.exp_pass));
        chk({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
        chk({tag, "_signature"}, signature, model);
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
        chk({tag, "_beats"}, 32'(beats_acc), 32'(NS));
        chk({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_pass_held"}, 32'(pass), 32'(v.exp_pass));
        sb_q.delete();
        rdy = 1'b1;
    endtask

    initial begin
        vecs[0] = mk(2'd2, 1'b0, 32'h0,        1'b1, 16'h0000, 16'h0001, 16'h0002, 16'h0003);
        vecs[1] = mk(2'd2, 1'b0, 32'h1,        1'b0, 16'h0000, 16'h0001, 16'h0002, 16'h0003);
        vecs[2] = mk(2'd0, 1'b1, 32'h0,        1'b1, 16'h4000, 16'h0000, 16'h0000, 16'h0000);
        vecs[3] = mk(2'd3, 1'b0, 32'h0,        1'b1, 16'h0001, 16'hB400, 16'h5A00, 16'h2D00);
        vecs[4] = mk(2'd1, 1'b1, 32'h0,        1'b1, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
        vecs[5] = mk(2'd3, 1'b1, 32'h8000_0000, 1'b0, 16'h0001, 16'hB400, 16'h5A00, 16'h2D00);

        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_stim_valid", 32'(bus.stim_valid), 32'd0);
        chk("rst_stim_data", 32'(bus.stim_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_signature", signature, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], 1'b1, vecs[i].toggle ? 0 : 6, 1'b0, $sformatf("vec%0d", i));
        end

        // A response while idle is an extra; pass from the last run stays held.
        inj_valid = 1'b1;
        @(posedge clk); #1;
        inj_valid = 1'b0;
        chk("idle_err_count", 32'(err_count), 32'd1);
        chk("idle_pass_held", 32'(pass), 32'd0);

        // Reset in the middle of DRIVE, then a clean rerun.
        for (int i = 0; i < NS; i++) sb_q.push_back(16'(i));
        lb_en = 1'b1; rdy = 1'b1; mode = 2'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        sb_q.delete();
        chk("midrst_stim_valid", 32'(bus.stim_valid), 32'd0);
        chk("midrst_stim_data", 32'(bus.stim_data), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_pass", 32'(pass), 32'd0);
        chk("midrst_timeout", 32'(timeout), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        chk("midrst_signature", signature, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_no_done", 32'(done), 32'd0);
        run_vec(vecs[0], 1'b1, 6, 1'b0, "rerun");

`ifdef FIR_BIST_TIMEOUT_EN
        // Silent DUT: watchdog forces CHECK, pass=0, timeout=1.
        run_vec(mk(2'd2, 1'b0, 32'h0, 1'b0, 16'h0000, 16'h0001, 16'h0002, 16'h0003),
                1'b0, 18, 1'b1, "wdog");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
